// File: rtl/fetch_group_buffer.sv
// Fetch group buffer: cuts each incoming fetch group after its first taken
// branch (or faulting slot), compacts the surviving slots into a circular
// buffer, drains up to NR_ISSUE entries per cycle to decode, and emits a
// registered one-cycle redirect carrying the cutting branch's target.

package riscv_pkg;
  typedef logic [31:0] addr_t;
endpackage

package tortoise_pkg;
  localparam int unsigned INSTR_PER_FETCH = 4;

  typedef struct packed {
    logic              is_taken;
    riscv_pkg::addr_t  target_addr;
  } branchpredict_t;

  typedef struct packed {
    riscv_pkg::addr_t  address;
    logic [31:0]       instruction;
    branchpredict_t    predict;
    logic              valid;
  } fetch_entry_t;
endpackage

module fetch_group_buffer #(
  parameter int unsigned NR_INSTRS   = tortoise_pkg::INSTR_PER_FETCH,
  parameter int unsigned NR_ISSUE    = 2,
  parameter int unsigned DEPTH       = 8,
  parameter bit          EX_AS_TAKEN = 1'b1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic                                     group_valid_i,
  output logic                                     group_ready_o,
  input  tortoise_pkg::fetch_entry_t [NR_INSTRS-1:0] instrs_i,
  input  logic [NR_INSTRS-1:0]                     exception_i,
  output logic                                     redirect_valid_o,
  output riscv_pkg::addr_t                         redirect_addr_o,
  output logic [NR_ISSUE-1:0]                      out_valid_o,
  output tortoise_pkg::fetch_entry_t [NR_ISSUE-1:0]  out_instrs_o,
  input  logic [$clog2(NR_ISSUE+1)-1:0]            out_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]               count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (NR_INSTRS > 1) ? $clog2(NR_INSTRS) : 1;

  tortoise_pkg::fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          redirect_valid_q;
  riscv_pkg::addr_t redirect_addr_q;

  logic          accept;
  logic          cut_found;
  logic [IW-1:0] cut_idx;
  logic          cut_taken;
  tortoise_pkg::fetch_entry_t [NR_INSTRS-1:0] push_data;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] push_eff;
  logic [CW-1:0] n_avail;

  // Ready depends only on the registered occupancy, never on same-cycle pops.
  assign group_ready_o = (count_q <= CW'(DEPTH - NR_INSTRS));
  assign accept        = group_valid_i & group_ready_o & ~flush_i;
  assign push_eff      = accept ? push_cnt : '0;

  // Locate the first slot that cuts the group; default to the last slot.
  always_comb begin
    cut_found = 1'b0;
    cut_idx   = IW'(NR_INSTRS - 1);
    for (int unsigned k = 0; k < NR_INSTRS; k++) begin
      if (!cut_found && instrs_i[k].valid &&
          (instrs_i[k].predict.is_taken || (EX_AS_TAKEN && exception_i[k]))) begin
        cut_found = 1'b1;
        cut_idx   = IW'(k);
      end
    end
    cut_taken = instrs_i[cut_idx].valid && instrs_i[cut_idx].predict.is_taken;
  end

  // Pack the valid slots up to and including the cut slot into consecutive lanes.
  always_comb begin
    int unsigned n;
    n         = 0;
    push_data = '0;
    for (int unsigned k = 0; k < NR_INSTRS; k++) begin
      if ((IW'(k) <= cut_idx) && instrs_i[k].valid) begin
        push_data[IW'(n)] = instrs_i[k];
        n = n + 1;
      end
    end
    push_cnt = CW'(n);
  end

  // Pointer and occupancy bookkeeping; flush discards everything and ignores acks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_eff);
      rd_ptr_q <= rd_ptr_q + PW'(out_ack_i);
      count_q  <= count_q + push_eff - CW'(out_ack_i);
    end
  end

  // Registered one-cycle redirect, armed only when the cut came from a taken branch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
    end else if (flush_i) begin
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
    end else begin
      redirect_valid_q <= accept & cut_taken;
      redirect_addr_q  <= (accept & cut_taken) ? instrs_i[cut_idx].predict.target_addr : '0;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NR_INSTRS; k++) begin
      if (accept && (CW'(k) < push_cnt)) begin
        mem_q[wr_ptr_q + PW'(k)] <= push_data[k];
      end
    end
  end

  // Present the oldest entries with a thermometer valid mask.
  always_comb begin
    for (int unsigned i = 0; i < NR_ISSUE; i++) begin
      out_valid_o[i]  = (count_q > CW'(i));
      out_instrs_o[i] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

  // Number of entries decode may legally consume this cycle.
  always_comb begin
    n_avail = (count_q > CW'(NR_ISSUE)) ? CW'(NR_ISSUE) : count_q;
  end

  ack_within_occupancy: assert property (
    @(posedge clk_i) disable iff (!rst_ni || flush_i)
    CW'(out_ack_i) <= n_avail
  );

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_addr_o  = redirect_addr_q;
  assign count_o          = count_q;

endmodule

// File: doc/fetch_group_buffer.md
# fetch_group_buffer

Sequential successor to the combinational taken-branch filter in the fetch stage. It accepts whole fetch groups and truncates each group after its first taken branch or, optionally, its first faulting instruction. It compacts the surviving instructions into a circular buffer and drains them to decode up to NR_ISSUE per cycle. It also emits a registered one-cycle redirect request carrying the predicted target of the cutting branch.

## Interface
- NR_INSTRS, default tortoise_pkg::INSTR_PER_FETCH: slots per fetch group.
- NR_ISSUE, default 2: max instructions presented to decode per cycle; range 1..NR_INSTRS.
- DEPTH, default 8: buffer entries; power of two; must satisfy DEPTH >= NR_INSTRS.
- EX_AS_TAKEN, default 1: when 1, a slot with exception_i set also cuts the group.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard buffer contents and any pending redirect.
- group_valid_i  in  1  fetch group presented.
- group_ready_o  out  1  buffer can absorb a full group.
- instrs_i  in  NR_INSTRS x tortoise_pkg::fetch_entry_t  group slots. Uses .valid, .predict.is_taken and .predict.target_addr.
- exception_i  in  NR_INSTRS  per-slot fetch fault.
- redirect_valid_o  out  1  one-cycle redirect pulse.
- redirect_addr_o  out  riscv_pkg::addr_t  redirect target; '0 when not valid.
- out_valid_o  out  NR_ISSUE  thermometer mask, bit i set if buffer holds more than i entries.
- out_instrs_o  out  NR_ISSUE x fetch_entry_t  oldest entries, oldest at index 0.
- out_ack_i  in  $clog2(NR_ISSUE+1)  number of entries consumed this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- **Accept:** a group is accepted when group_valid_i & group_ready_o & ~flush_i.
- **Ready:** group_ready_o = (DEPTH - count) >= NR_INSTRS. It is computed from the registered count only; same-cycle pops do not raise it.
- **Cut index:**
  - cut[k] = instrs_i[k].valid & (instrs_i[k].predict.is_taken | (EX_AS_TAKEN & exception_i[k])).
  - c = lowest k with cut[k] set; c = NR_INSTRS-1 if no slot cuts.
- **Kept slots:** slots 0..c with .valid=1.
  - Pushed in ascending slot order to consecutive buffer entries, with gaps compacted.
  - Slots above c are dropped.
  - Stored entries are unmodified and keep valid=1.
- **Redirect:** armed only if slot c cut because predict.is_taken=1.
  - Registered: redirect_valid_o=1 and redirect_addr_o = instrs_i[c].predict.target_addr in the cycle after accept.
  - If slot c is both taken and faulting, a redirect is still issued.
  - If slot c cut by exception only, no redirect is issued.
- **Drain:**
  - out_ack_i=n pops the n oldest entries.
  - n must not exceed popcount(out_valid_o); an assertion fires on violation and the design behaviour is undefined.
- **Pointers:** rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count = count + pushed - n, saturation-free by construction.
- **Simultaneous push and pop:** both applied in the same cycle.
- **Flush:**
  - Pointers and count are zeroed at the next edge.
  - The group presented this cycle is not accepted.
  - A redirect registered in this cycle is cleared; redirect_valid_o is 0 next cycle.
  - out_ack_i is ignored.
- **Empty group:** an accepted group with no valid slots pushes nothing and issues no redirect.

## Timing
- **Reset values:**
  - redirect_valid_o=0, redirect_addr_o='0, count_o=0, out_valid_o=0.
  - group_ready_o=1; out_instrs_o content is don't-care.
- **Reset during operation:** asynchronous; all state clears immediately and in-flight data and redirects are lost.
- **Latency:** accepted instructions appear on out_* one cycle after the accept edge. Redirect also follows one cycle after the accept edge.
- **Redirect pulse:** lasts exactly one cycle, with no back-pressure on it.
- **Pops:** take effect at the edge; out_* shows the next oldest entries the following cycle.
- **Full buffer:** group_ready_o=0 whenever fewer than NR_INSTRS entries are free, even if the incoming group would fit after truncation.
- **count_o:** registered; reflects state after the last edge.

## Test plan
Configuration for all tests: NR_INSTRS=4, NR_ISSUE=2, DEPTH=8.
- **No cut:** group of 4 valid slots, no taken, no fault.
  - Required: count_o=4 next cycle, out_valid_o=2'b11 showing slots 0,1, no redirect.
- **Taken branch cut:** slot 1 taken with target 0x8000_0040.
  - Required: count_o=2 next cycle; redirect_valid_o=1 for one cycle with redirect_addr_o=0x8000_0040; slots 2,3 never appear.
- **Compaction and fault cut, EX_AS_TAKEN=1:** slot 0 invalid, slot 2 faulting, slot 3 taken.
  - Required: slots 1,2 stored at buffer entries 0,1; no redirect.
- **Fill to full:** push 2 full groups with out_ack_i=0.
  - Required: count_o=8 and group_ready_o=0.
  - Then ack 2 per cycle for 2 cycles: group_ready_o reasserts when count_o=4.
- **Wrap-around:** push and drain more than 8 entries with concurrent push and pop.
  - Required: output order matches input order across the pointer wrap.
- **Flush:** flush in the same cycle as accepting a taken group, with count_o=5.
  - Required: count_o=0 next cycle, no redirect pulse, group not stored.
- **Reset:** assert rst_ni mid-burst.
  - Required: outputs return to reset values immediately.
